mips_inst_encoder: RTL and testbench

//  Encoder counterpart of the control decoder. Takes instruction requests as a kind code plus register, immediate and target fields.

---
 rtl/mips_enc_pkg.sv | 42 ++++
 rtl/enc_fifo.sv | 43 ++++
 rtl/mips_inst_encoder.sv | 117 +++++++++++
 tb/tb_mips_inst_encoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_enc_pkg.sv
// Shared kind codes, opcode/func fields and the legality check for the MIPS instruction encoder.
package mips_enc_pkg;

    typedef enum logic [3:0] {
        K_ADD   = 4'd0,
        K_SUB   = 4'd1,
        K_AND   = 4'd2,
        K_OR    = 4'd3,
        K_SLT   = 4'd4,
        K_ORI   = 4'd5,
        K_ADDIU = 4'd6,
        K_LW    = 4'd7,
        K_SW    = 4'd8,
        K_BEQ   = 4'd9,
        K_J     = 4'd10
    } kind_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    function automatic logic is_legal(input logic [3:0] kind);
        return kind <= 4'd10;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO for {addr, word} entries; read data holds the last popped entry while empty.
module enc_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]       wr_ptr, rd_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  last;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign rdata = empty ? last : mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last   <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
                last   <= mem[rd_ptr[PW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mips_inst_encoder.sv
// Packs kind/field requests into MIPS words tagged with a running address and queues them.
// Define ENC_STATS_EN to add saturating stat_words/stat_illegal counters.
module mips_inst_encoder
    import mips_enc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int ADDR_STEP  = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_kind,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_inst,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  err_illegal,
    output logic                  done
`ifdef ENC_STATS_EN
    ,
    output logic [15:0]           stat_words,
    output logic [7:0]            stat_illegal
`endif
);
    state_e                state;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [31:0]           word;
    logic                  accept, legal, push, pop, full, empty;

    assign in_ready  = (state == S_RUN) && !full;
    assign accept    = in_valid && in_ready;
    assign legal     = is_legal(in_kind);
    assign push      = accept && legal;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    always_comb begin
        word = '0;
        case (in_kind)
            K_ADD:   word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_ADD};
            K_SUB:   word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_SUB};
            K_AND:   word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_AND};
            K_OR:    word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_OR};
            K_SLT:   word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_SLT};
            K_ORI:   word = {OP_ORI,   in_rs, in_rt, in_imm};
            K_ADDIU: word = {OP_ADDIU, in_rs, in_rt, in_imm};
            K_LW:    word = {OP_LW,    in_rs, in_rt, in_imm};
            K_SW:    word = {OP_SW,    in_rs, in_rt, in_imm};
            K_BEQ:   word = {OP_BEQ,   in_rs, in_rt, in_imm};
            K_J:     word = {OP_J,     in_target};
            default: word = '0;
        endcase
    end

    enc_fifo #(
        .WIDTH(ADDR_WIDTH + 32),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({addr_cnt, word}),
        .rdata ({out_addr, out_inst}),
        .full  (full),
        .empty (empty)
    );

    // stop leaves RUN even when a request is accepted on the same edge; that request still lands.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= S_IDLE;
            addr_cnt     <= '0;
            err_illegal  <= 1'b0;
            done         <= 1'b0;
`ifdef ENC_STATS_EN
            stat_words   <= '0;
            stat_illegal <= '0;
`endif
        end else begin
            err_illegal <= accept && !legal;
            done        <= 1'b0;
            if (push) addr_cnt <= addr_cnt + ADDR_WIDTH'(ADDR_STEP);
`ifdef ENC_STATS_EN
            if (push && stat_words != 16'hFFFF) stat_words <= stat_words + 16'd1;
            if (accept && !legal && stat_illegal != 8'hFF) stat_illegal <= stat_illegal + 8'd1;
`endif
            case (state)
                S_IDLE: if (start) begin
                    state    <= S_RUN;
                    addr_cnt <= base_addr;
`ifdef ENC_STATS_EN
                    stat_words   <= '0;
                    stat_illegal <= '0;
`endif
                end
                S_RUN:   if (stop) state <= S_DRAIN;
                S_DRAIN: if (empty) begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_inst_encoder.sv
// Randomized bench for mips_inst_encoder: queue-based reference model checked every cycle plus literal pins.
module tb_mips_inst_encoder;
    localparam int DEPTH = 4;
    localparam int FN_T [5] = '{32, 34, 36, 37, 42};
    localparam int OP_T [5] = '{13, 9, 35, 43, 4};

    logic        sys_clk = 1'b0, sys_rst_n = 1'b0, start = 1'b0, stop = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] base_addr = '0;
    logic [3:0]  in_kind = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        in_ready, out_valid, err_illegal, done;
    logic [31:0] out_inst, out_addr;
`ifdef ENC_STATS_EN
    logic [15:0] stat_words;
    logic [7:0]  stat_illegal;
    logic [15:0] sw_m;
    logic [7:0]  si_m;
`endif

    mips_inst_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(32), .ADDR_STEP(4)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop),
        .base_addr(base_addr), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
        .err_illegal(err_illegal), .done(done)
`ifdef ENC_STATS_EN
        , .stat_words(stat_words), .stat_illegal(stat_illegal)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0, n_fail = 0;
    int mst = 0;                 // 0 idle, 1 run, 2 drain
    logic [63:0] q[$];
    logic [63:0] obs[$];
    logic [63:0] last_m = '0;
    logic [31:0] addr_m = '0;
    logic        err_m = 1'b0, done_m = 1'b0;
    int          err_seen = 0, done_seen = 0;

    function automatic logic [31:0] ref_enc(input int k, input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        if (k <= 4)
            return 32'(rs) * 32'h200000 + 32'(rt) * 32'h10000 + 32'(rd) * 32'h800 + 32'(FN_T[k]);
        if (k <= 9)
            return 32'(OP_T[k-5]) * 32'h4000000 + 32'(rs) * 32'h200000 + 32'(rt) * 32'h10000 + 32'(imm);
        return 32'h08000000 + 32'(tgt);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mst = 0; q.delete(); last_m = '0; addr_m = '0; err_m = 1'b0; done_m = 1'b0;
`ifdef ENC_STATS_EN
        sw_m = '0; si_m = '0;
`endif
    endtask

    // Predicts the effect of the upcoming clock edge from pre-edge model state and current inputs.
    task automatic model_step();
        int  sz;
        bit  rdy, acc, leg, pp;
        if (!sys_rst_n) begin model_reset(); return; end
        sz  = q.size();
        rdy = (mst == 1) && (sz < DEPTH);
        acc = in_valid && rdy;
        leg = (in_kind <= 4'd10);
        pp  = (sz > 0) && out_ready;
        err_m  = acc && !leg;
        done_m = 1'b0;
        if (pp) last_m = q.pop_front();
        if (acc && leg) begin
            q.push_back({addr_m, ref_enc(int'(in_kind), in_rs, in_rt, in_rd, in_imm, in_target)});
            addr_m = addr_m + 32'd4;
`ifdef ENC_STATS_EN
            if (sw_m != 16'hFFFF) sw_m++;
`endif
        end
`ifdef ENC_STATS_EN
        if (acc && !leg && si_m != 8'hFF) si_m++;
`endif
        case (mst)
            0: if (start) begin
                mst = 1; addr_m = base_addr;
`ifdef ENC_STATS_EN
                sw_m = '0; si_m = '0;
`endif
            end
            1: if (stop) mst = 2;
            default: if (sz == 0) begin mst = 0; done_m = 1'b1; end
        endcase
    endtask

    task automatic check();
        logic [63:0] e;
        e = (q.size() > 0) ? q[0] : last_m;
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'((mst == 1) && (q.size() < DEPTH)));
        chk("err_illegal", 64'(err_illegal), 64'(err_m));
        chk("done", 64'(done), 64'(done_m));
        chk("out_inst", 64'(out_inst), 64'(e[31:0]));
        chk("out_addr", 64'(out_addr), 64'(e[63:32]));
`ifdef ENC_STATS_EN
        chk("stat_words", 64'(stat_words), 64'(sw_m));
        chk("stat_illegal", 64'(stat_illegal), 64'(si_m));
`endif
        if (out_valid && out_ready) obs.push_back({out_addr, out_inst});
        if (err_illegal) err_seen++;
        if (done) done_seen++;
    endtask

    // One cycle: compare at negedge, advance model, inputs change 2ns after posedge.
    task automatic step();
        @(negedge sys_clk);
        check();
        model_step();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [15:0] imm, input logic [25:0] tgt);
        bit ok = 1'b0;
        in_valid = 1'b1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = in_ready;
            step();
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] b);
        base_addr = b; start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && !(mst == 0 && q.size() == 0 && !done_m); i++) step();
        if (!(mst == 0 && q.size() == 0)) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_inst", 64'(out_inst), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_err", 64'(err_illegal), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        step(); step();
        sys_rst_n = 1'b1;
        step();
    endtask

    initial begin
        int acc_n;
        logic [31:0] lit_i [8];
        logic [31:0] lit_a [8];
        #2;
        do_reset();

        // Directed encodings, including an illegal kind between two ADDs.
        out_ready = 1'b1;
        pulse_start(32'h0);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        send(4'd7, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);
        send(4'd5, 5'd0, 5'd5, 5'd0, 16'h00FF, 26'h0);
        send(4'd9, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
        send(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
        err_seen = 0;
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        send(4'd12, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h0);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        for (int i = 0; i < 4; i++) step();
        lit_i = '{32'h00221820, 32'h8FA80004, 32'h340500FF, 32'h1022FFFF, 32'h08100000, 32'h00221820, 32'h00221820, 32'h0};
        lit_a = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h0};
        chk("dir_count", 64'(obs.size()), 64'd7);
        for (int i = 0; i < 7 && i < obs.size(); i++) begin
            chk("dir_inst", 64'(obs[i][31:0]), 64'(lit_i[i]));
            chk("dir_addr", 64'(obs[i][63:32]), 64'(lit_a[i]));
        end
        chk("dir_err_pulses", 64'(err_seen), 64'd1);

        // Fill to full with consumer stalled.
        obs.delete();
        out_ready = 1'b0;
        pulse_stop(); wait_idle();
        pulse_start(32'h100);
        in_valid = 1'b1; in_kind = 4'd1; in_rs = 5'd4; in_rt = 5'd5; in_rd = 5'd6;
        acc_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (in_ready) acc_n++;
            step();
        end
        chk("full_accepts", 64'(acc_n), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_stall_addr", 64'(out_addr), 64'h100);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        for (int i = 0; i < 3; i++) step();
        chk("full_count", 64'(obs.size()), 64'd5);
        for (int i = 0; i < 5 && i < obs.size(); i++) begin
            chk("full_addr", 64'(obs[i][63:32]), 64'(32'h100 + 32'(4 * i)));
            chk("full_inst", 64'(obs[i][31:0]), 64'h00853022);
        end

        // Stop with three queued: done only after they drain.
        obs.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(4'd3, 5'(i), 5'd1, 5'd2, 16'h0, 26'h0);
        pulse_stop();
        done_seen = 0;
        step(); step();
        chk("drain_no_early_done", 64'(done_seen), 64'd0);
        out_ready = 1'b1;
        wait_idle(); step();
        chk("drain_pops", 64'(obs.size()), 64'd3);
        chk("drain_done", 64'(done_seen), 64'd1);

        // Address wrap.
        obs.delete();
        pulse_start(32'hFFFFFFFC);
        send(4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
        send(4'd2, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
        for (int i = 0; i < 3; i++) step();
        chk("wrap_count", 64'(obs.size()), 64'd2);
        if (obs.size() == 2) begin
            chk("wrap_addr0", 64'(obs[0][63:32]), 64'hFFFFFFFC);
            chk("wrap_addr1", 64'(obs[1][63:32]), 64'h0);
        end

        // Random traffic, start/stop sprinkled in.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_kind   = 4'($urandom_range(0, 15));
            in_rs     = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
            in_imm    = 16'($urandom); in_target = 26'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            start     = ($urandom_range(0, 9) == 0);
            stop      = ($urandom_range(0, 49) == 0);
            base_addr = $urandom & 32'hFFFFFFFC;
            step();
        end
        in_valid = 1'b0; start = 1'b0; stop = 1'b0;

        // Reset mid-operation with two words queued.
        do_reset();
        out_ready = 1'b0;
        pulse_start(32'h40);
        send(4'd6, 5'd3, 5'd4, 5'd0, 16'h8000, 26'h0);
        send(4'd8, 5'd3, 5'd4, 5'd0, 16'h0010, 26'h0);
        step();
        chk("mid_queued_valid", 64'(out_valid), 64'd1);
        chk("mid_queued_inst", 64'(out_inst), 64'h24648000);
        do_reset();
        for (int i = 0; i < 3; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
